// File: rtl/pll_phase_sequencer.sv
// pll_phase_sequencer
// Runtime phase-adjust controller for the ECP5 EHXPLLL dynamic phase port.
// Takes "shift output X by N steps in direction D" requests, sequences
// PHASESEL/PHASEDIR/PHASESTEP, then waits for the PLL to re-lock before
// pulsing done. Tracks an 8-bit phase position per PLL output.
module pll_phase_sequencer #(
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 4,
    parameter int GAP_CYC      = 4,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    input  logic       locked,
    output logic [1:0] phasesel,
    output logic       phasedir,
    output logic       phasestep,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic [1:0] pos_sel,
    output logic [7:0] pos
);

    // One shared phase counter covers SETUP, PULSE and GAP; size it for the longest.
    localparam int PH_MAX = (SETUP_CYC > PULSE_CYC) ?
                            ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                            ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
    localparam int PH_W = $clog2(PH_MAX + 1);
    localparam int ST_W = $clog2(LOCK_STABLE + 1);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_CYC - 1);
    localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_CYC - 1);
    localparam logic [ST_W-1:0] ST_LAST    = ST_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [PH_W-1:0]   r_cnt;
    logic [ST_W-1:0]   r_scnt;
    logic [TO_W-1:0]   r_tcnt;
    logic [7:0]        r_rem;
    logic [1:0]        r_sel;
    logic              r_dir;
    logic              r_phasestep;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [3:0][7:0]   r_pos;
    logic [1:0]        r_lock_sync;
    logic              w_lock_s;

    assign w_lock_s  = r_lock_sync[1];
    assign req_ready = (r_state == S_IDLE) && !rst;
    assign phasesel  = r_sel;
    assign phasedir  = r_dir;
    assign phasestep = r_phasestep;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign pos       = r_pos[pos_sel];

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_lock_sync <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], locked};
        end
    end

    // Main sequencer: accept, step pulses, settle on lock, report completion.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_scnt      <= '0;
            r_tcnt      <= '0;
            r_rem       <= '0;
            r_sel       <= 2'd0;
            r_dir       <= 1'b1;
            r_phasestep <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_pos       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // req_ready is exactly (IDLE && !rst), so valid alone accepts here.
                    if (req_valid) begin
                        r_sel  <= req_sel;
                        r_dir  <= req_dir;
                        r_rem  <= req_steps;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        if (req_steps == 8'd0) begin
                            // Nothing to step: complete immediately, no settle.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt       <= '0;
                        r_phasestep <= 1'b0;
                        r_state     <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_cnt       <= '0;
                        r_phasestep <= 1'b1;
                        r_rem       <= r_rem - 8'd1;
                        // Position wraps modulo 256 in both directions.
                        r_pos[r_sel] <= r_dir ? (r_pos[r_sel] + 8'd1)
                                              : (r_pos[r_sel] - 8'd1);
                        if (r_rem > 8'd1) begin
                            r_state <= S_GAP;
                        end else begin
                            r_scnt  <= '0;
                            r_tcnt  <= '0;
                            r_state <= S_SETTLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt       <= '0;
                        r_phasestep <= 1'b0;
                        r_state     <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_lock_s) begin
                        r_scnt <= r_scnt + 1'b1;
                    end else begin
                        r_scnt <= '0;
                    end
                    // Stable lock is checked first so it wins over a coincident timeout.
                    if (w_lock_s && (r_scnt == ST_LAST)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                    end else if (r_tcnt == TO_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
